// File: rtl/pirad_axil_pkg.sv
// Shared types and helpers for the pirad AXI4-Lite register bank.
// Response codes, address-to-register decode and the data-width legality test.
package pirad_axil_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    function automatic bit data_width_ok(input int unsigned data_width);
        return (data_width == 32) || (data_width == 64);
    endfunction

    // Register index of a byte address; the byte-offset bits are dropped.
    function automatic int unsigned addr_to_index(input logic [31:0] addr,
                                                  input int unsigned data_width);
        logic [31:0] idx;
        idx = (data_width == 64) ? (addr >> 3) : (addr >> 2);
        return idx;
    endfunction

endpackage

// File: rtl/pirad_axil_hold.sv
// One-entry valid/ready holding register. The entry may be consumed directly
// from the input in the cycle it handshakes, or later from the held copy.
module pirad_axil_hold #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    input  logic             consume_i,
    output logic             ready_o,
    output logic             avail_o,
    output logic [Width-1:0] data_o
);

    logic             held_q;
    logic [Width-1:0] data_q;

    assign ready_o = en_i && !held_q;
    assign avail_o = held_q || (valid_i && ready_o);
    assign data_o  = held_q ? data_q : data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            held_q <= 1'b0;
            data_q <= '0;
        end else if (consume_i) begin
            held_q <= 1'b0;
        end else if (valid_i && ready_o) begin
            held_q <= 1'b1;
            data_q <= data_i;
        end
    end

endmodule

// File: rtl/pirad_axil_regbank.sv
// Parametrised AXI4-Lite slave register bank with byte strobes, read-only
// status registers, SLVERR on bad accesses and per-register access strobes.
module pirad_axil_regbank
    import pirad_axil_pkg::*;
#(
    parameter int unsigned                 DATA_WIDTH = 32,
    parameter int unsigned                 ADDR_WIDTH = 8,
    parameter int unsigned                 NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]         RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0]       RESET_VAL  = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            reg_wr,
    output logic [NUM_REGS-1:0]            reg_rd
);

    localparam int unsigned StrbW = DATA_WIDTH / 8;

    if (!data_width_ok(DATA_WIDTH)) begin : g_bad_width
        $error("pirad_axil_regbank: DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS * StrbW > (1 << ADDR_WIDTH)) begin : g_bad_addr
        $error("pirad_axil_regbank: register map does not fit in ADDR_WIDTH");
    end

    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Ready outputs stay low until the first clock after reset release.
    logic rdy_en_q;

    logic                  aw_ready, aw_avail;
    logic                  w_ready, w_avail;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [StrbW-1:0]      w_strb;
    logic                  wr_commit;
    int unsigned           widx, ridx;
    logic [NUM_REGS-1:0]   wr_onehot, rd_onehot;
    logic                  wr_ok, rd_hit;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  ar_fire;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  bvalid_q, rvalid_q;
    resp_t                 bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [NUM_REGS-1:0]   reg_wr_q, reg_rd_q;

    pirad_axil_hold #(
        .Width (ADDR_WIDTH)
    ) u_aw_hold (
        .clk_i     (ACLK),
        .rst_ni    (ARESETN),
        .en_i      (rdy_en_q),
        .valid_i   (S_AXI_AWVALID),
        .data_i    (S_AXI_AWADDR),
        .consume_i (wr_commit),
        .ready_o   (aw_ready),
        .avail_o   (aw_avail),
        .data_o    (aw_addr)
    );

    pirad_axil_hold #(
        .Width (DATA_WIDTH + StrbW)
    ) u_w_hold (
        .clk_i     (ACLK),
        .rst_ni    (ARESETN),
        .en_i      (rdy_en_q),
        .valid_i   (S_AXI_WVALID),
        .data_i    ({S_AXI_WSTRB, S_AXI_WDATA}),
        .consume_i (wr_commit),
        .ready_o   (w_ready),
        .avail_o   (w_avail),
        .data_o    ({w_strb, w_data})
    );

    assign wr_commit = aw_avail && w_avail && (!bvalid_q || S_AXI_BREADY);
    assign widx      = addr_to_index(32'(aw_addr), DATA_WIDTH);
    assign ridx      = addr_to_index(32'(S_AXI_ARADDR), DATA_WIDTH);
    assign ar_fire   = S_AXI_ARVALID && S_AXI_ARREADY;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
        assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] =
            RO_MASK[gi] ? reg_in[gi*DATA_WIDTH +: DATA_WIDTH] : regs_q[gi];
    end

    always_comb begin
        wr_onehot = '0;
        rd_onehot = '0;
        rd_hit    = 1'b0;
        rd_val    = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (widx == i) wr_onehot[i] = !RO_MASK[i];
            if (ridx == i) begin
                rd_onehot[i] = 1'b1;
                rd_hit       = 1'b1;
                rd_val       = reg_out[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        wr_ok = |wr_onehot;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else if (wr_commit) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                for (int unsigned b = 0; b < StrbW; b++) begin
                    if (wr_onehot[i] && w_strb[b]) regs_q[i][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdy_en_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            reg_wr_q <= '0;
            reg_rd_q <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            reg_wr_q <= '0;
            reg_rd_q <= '0;
            if (wr_commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                reg_wr_q <= wr_onehot;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
                rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
                reg_rd_q <= rd_onehot;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = rdy_en_q && (!rvalid_q || S_AXI_RREADY);
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_wr        = reg_wr_q;
    assign reg_rd        = reg_rd_q;

endmodule

// File: tb/tb_pirad_axil_regbank.sv
// Bench for pirad_axil_regbank: a 32-bit/16-register instance with register 5
// read-only, plus a 64-bit/4-register instance for the wide-data and reset cases.
module tb_pirad_axil_regbank;
    import pirad_axil_pkg::*;

    localparam int unsigned NR = 16;
    localparam logic [NR-1:0] RO = 16'h0020;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst6_n;

    // 32-bit instance
    logic [7:0]       awaddr, araddr;
    logic             awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]      wdata, rdata;
    logic [3:0]       wstrb;
    logic             awready, wready, bvalid, arready, rvalid;
    logic [1:0]       bresp, rresp;
    logic [NR*32-1:0] reg_out, reg_in;
    logic [NR-1:0]    reg_wr, reg_rd;

    // 64-bit instance
    logic [7:0]       awaddr6, araddr6;
    logic             awvalid6, wvalid6, bready6, arvalid6, rready6;
    logic [63:0]      wdata6, rdata6;
    logic [7:0]       wstrb6;
    logic             awready6, wready6, bvalid6, arready6, rvalid6;
    logic [1:0]       bresp6, rresp6;
    logic [4*64-1:0]  reg_out6, reg_in6;
    logic [3:0]       reg_wr6, reg_rd6;

    pirad_axil_regbank #(
        .DATA_WIDTH (32), .ADDR_WIDTH (8), .NUM_REGS (NR), .RO_MASK (RO), .RESET_VAL (32'h0)
    ) dut (
        .ACLK (clk), .ARESETN (rst_n),
        .S_AXI_AWADDR (awaddr), .S_AXI_AWPROT (3'b000), .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready), .S_AXI_WDATA (wdata), .S_AXI_WSTRB (wstrb),
        .S_AXI_WVALID (wvalid), .S_AXI_WREADY (wready), .S_AXI_BRESP (bresp),
        .S_AXI_BVALID (bvalid), .S_AXI_BREADY (bready), .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (3'b000), .S_AXI_ARVALID (arvalid), .S_AXI_ARREADY (arready),
        .S_AXI_RDATA (rdata), .S_AXI_RRESP (rresp), .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready), .reg_out (reg_out), .reg_in (reg_in),
        .reg_wr (reg_wr), .reg_rd (reg_rd)
    );

    pirad_axil_regbank #(
        .DATA_WIDTH (64), .ADDR_WIDTH (8), .NUM_REGS (4), .RO_MASK (4'b0000), .RESET_VAL (64'h0)
    ) dut64 (
        .ACLK (clk), .ARESETN (rst6_n),
        .S_AXI_AWADDR (awaddr6), .S_AXI_AWPROT (3'b000), .S_AXI_AWVALID (awvalid6),
        .S_AXI_AWREADY (awready6), .S_AXI_WDATA (wdata6), .S_AXI_WSTRB (wstrb6),
        .S_AXI_WVALID (wvalid6), .S_AXI_WREADY (wready6), .S_AXI_BRESP (bresp6),
        .S_AXI_BVALID (bvalid6), .S_AXI_BREADY (bready6), .S_AXI_ARADDR (araddr6),
        .S_AXI_ARPROT (3'b000), .S_AXI_ARVALID (arvalid6), .S_AXI_ARREADY (arready6),
        .S_AXI_RDATA (rdata6), .S_AXI_RRESP (rresp6), .S_AXI_RVALID (rvalid6),
        .S_AXI_RREADY (rready6), .reg_out (reg_out6), .reg_in (reg_in6),
        .reg_wr (reg_wr6), .reg_rd (reg_rd6)
    );

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt [NR] = '{default: 0};
    int rd_cnt [NR] = '{default: 0};

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (reg_wr[i]) wr_cnt[i] <= wr_cnt[i] + 1;
            if (reg_rd[i]) rd_cnt[i] <= rd_cnt[i] + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: register file plus the access rules.
    logic [31:0] mregs [NR];

    function automatic logic [1:0] model_write(input int unsigned idx, input logic [31:0] d,
                                               input logic [3:0] s);
        if (idx >= NR || RO[idx]) return RESP_SLVERR;
        for (int b = 0; b < 4; b++) if (s[b]) mregs[idx][8*b +: 8] = d[8*b +: 8];
        return RESP_OKAY;
    endfunction

    task automatic model_read(input int unsigned idx, output logic [31:0] d,
                              output logic [1:0] r);
        if (idx >= NR) begin
            d = 32'h0;
            r = RESP_SLVERR;
        end else begin
            d = RO[idx] ? 32'hDEADBEEF : mregs[idx];
            r = RESP_OKAY;
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_hs, w_hs;
        int cyc = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while ((awvalid || wvalid) && cyc < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge clk);
            cyc++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
        end
        while (!bvalid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bvalid) begin
            n_vec++; n_err++;
            $display("FAIL write_timeout: addr %h got no B beat, expected BVALID=1", a);
        end
        resp = bresp;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        bit hs;
        int cyc = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (arvalid && cyc < 50) begin
            hs = arready;
            @(negedge clk);
            cyc++;
            if (hs) arvalid = 1'b0;
        end
        while (!rvalid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!rvalid) begin
            n_vec++; n_err++;
            $display("FAIL read_timeout: addr %h got no R beat, expected RVALID=1", a);
        end
        d = rdata; r = rresp;
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [$];
        logic [31:0] d, ed, old9;
        logic [1:0]  r, er, beat_resp [2];
        logic [7:0]  a;
        int unsigned idx;
        int          beats;
        bit          stable;

        for (int i = 0; i < NR; i++) begin
            mregs[i] = 32'h0;
            reg_in[i*32 +: 32] = $urandom;
        end
        reg_in[5*32 +: 32] = 32'hDEADBEEF;
        reg_in6 = '0;
        {awaddr, araddr, wdata, wstrb, awvalid, wvalid, arvalid} = '0;
        {awaddr6, araddr6, wdata6, wstrb6, awvalid6, wvalid6, arvalid6} = '0;
        bready = 1'b1; rready = 1'b1; bready6 = 1'b1; rready6 = 1'b1;
        rst_n = 1'b0; rst6_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_reg2", reg_out[2*32 +: 32], 0);
        rst_n = 1'b1; rst6_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {awready, wready, arready}, 3'b111);

        tbl.push_back('{1'b1, 8'h00, 32'h1, 4'hF, 32'h0, RESP_OKAY});
        tbl.push_back('{1'b1, 8'h04, 32'h2, 4'hF, 32'h0, RESP_OKAY});
        tbl.push_back('{1'b1, 8'h08, 32'h3, 4'hF, 32'h0, RESP_OKAY});
        tbl.push_back('{1'b1, 8'h0C, 32'h4, 4'hF, 32'h0, RESP_OKAY});
        tbl.push_back('{1'b0, 8'h00, 32'h0, 4'h0, 32'h1, RESP_OKAY});
        tbl.push_back('{1'b0, 8'h04, 32'h0, 4'h0, 32'h2, RESP_OKAY});
        tbl.push_back('{1'b0, 8'h08, 32'h0, 4'h0, 32'h3, RESP_OKAY});
        tbl.push_back('{1'b0, 8'h0C, 32'h0, 4'h0, 32'h4, RESP_OKAY});
        tbl.push_back('{1'b1, 8'h08, 32'hAABBCCDD, 4'hF, 32'h0, RESP_OKAY});
        tbl.push_back('{1'b1, 8'h08, 32'h11223344, 4'h5, 32'h0, RESP_OKAY});
        tbl.push_back('{1'b0, 8'h08, 32'h0, 4'h0, 32'hAA22CC44, RESP_OKAY});
        tbl.push_back('{1'b0, 8'h0B, 32'h0, 4'h0, 32'hAA22CC44, RESP_OKAY});
        tbl.push_back('{1'b1, 8'h14, 32'h12345678, 4'hF, 32'h0, RESP_SLVERR});
        tbl.push_back('{1'b0, 8'h14, 32'h0, 4'h0, 32'hDEADBEEF, RESP_OKAY});
        tbl.push_back('{1'b0, 8'h40, 32'h0, 4'h0, 32'h0, RESP_SLVERR});
        tbl.push_back('{1'b1, 8'h4C, 32'h9, 4'hF, 32'h0, RESP_SLVERR});
        tbl.push_back('{1'b1, 8'h0C, 32'h55555555, 4'h0, 32'h0, RESP_OKAY});
        tbl.push_back('{1'b0, 8'h0C, 32'h0, 4'h0, 32'h4, RESP_OKAY});

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
                er = model_write(32'(tbl[i].addr) >> 2, tbl[i].data, tbl[i].strb);
                check($sformatf("tbl%0d_bresp", i), r, tbl[i].exp_resp);
            end else begin
                axi_read(tbl[i].addr, d, r);
                check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_data);
                check($sformatf("tbl%0d_rresp", i), r, tbl[i].exp_resp);
            end
        end
        check("wr_cnt0", wr_cnt[0], 1);
        check("wr_cnt1", wr_cnt[1], 1);
        check("wr_cnt2", wr_cnt[2], 3);
        check("wr_cnt3_zero_strb", wr_cnt[3], 2);
        check("wr_cnt5_ro", wr_cnt[5], 0);
        check("rd_cnt5", rd_cnt[5], 1);
        check("reg_out2", reg_out[2*32 +: 32], 32'hAA22CC44);

        // W three cycles ahead of AW
        @(negedge clk);
        wdata = 32'hCAFE0001; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("wfirst_wready_held", wready, 0);
        check("wfirst_bvalid_pre", bvalid, 0);
        awaddr = 8'h08; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("wfirst_bvalid", bvalid, 1);
        check("wfirst_bresp", bresp, RESP_OKAY);
        @(negedge clk);
        er = model_write(2, 32'hCAFE0001, 4'hF);

        // AW three cycles ahead of W
        awaddr = 8'h08; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("awfirst_awready_held", awready, 0);
        repeat (2) @(negedge clk);
        wdata = 32'hCAFE0002; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("awfirst_bvalid", bvalid, 1);
        check("awfirst_bresp", bresp, RESP_OKAY);
        @(negedge clk);
        er = model_write(2, 32'hCAFE0002, 4'hF);
        axi_read(8'h08, d, r);
        check("awfirst_readback", d, 32'hCAFE0002);

        // B backpressure: two writes queued behind BREADY low
        bready = 1'b0;
        awaddr = 8'h18; wdata = 32'h66666666; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check("stall_b1_valid", bvalid, 1);
        awaddr = 8'h14; wdata = 32'h77777777;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("stall_ready_drop", {awready, wready}, 2'b00);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bvalid || bresp !== RESP_OKAY || awready) stable = 1'b0;
        end
        check("stall_b1_stable", stable, 1);
        bready = 1'b1;
        beats = 0;
        beat_resp[0] = 2'bxx; beat_resp[1] = 2'bxx;
        for (int c = 0; c < 6; c++) begin
            if (bvalid) begin
                if (beats < 2) beat_resp[beats] = bresp;
                beats++;
            end
            @(negedge clk);
        end
        check("stall_beats", beats, 2);
        check("stall_beat0", beat_resp[0], RESP_OKAY);
        check("stall_beat1", beat_resp[1], RESP_SLVERR);
        er = model_write(6, 32'h66666666, 4'hF);
        axi_read(8'h18, d, r);
        check("stall_data6", d, 32'h66666666);

        // Read and write of the same register committing together
        old9 = mregs[9];
        awaddr = 8'h24; araddr = 8'h24; wdata = 32'h0BADF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("rw_same_rvalid", rvalid, 1);
        check("rw_same_old_value", rdata, old9);
        check("rw_same_bvalid", bvalid, 1);
        @(negedge clk);
        er = model_write(9, 32'h0BADF00D, 4'hF);
        axi_read(8'h24, d, r);
        check("rw_same_new_value", d, 32'h0BADF00D);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            idx = $urandom_range(0, 19);
            a = 8'(idx * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                wstrb = 4'($urandom_range(0, 15));
                er = model_write(idx, d, wstrb);
                axi_write(a, d, wstrb, r);
                check($sformatf("rnd%0d_bresp", n), r, er);
                if (er == RESP_OKAY)
                    check($sformatf("rnd%0d_reg_out", n), reg_out[idx*32 +: 32], mregs[idx]);
            end else begin
                model_read(idx, ed, er);
                axi_read(a, d, r);
                check($sformatf("rnd%0d_rdata", n), d, ed);
                check($sformatf("rnd%0d_rresp", n), r, er);
            end
        end

        // 64-bit instance: write/read then reset in the middle of a read
        @(negedge clk);
        awaddr6 = 8'h18; wdata6 = 64'h0123456789ABCDEF; wstrb6 = 8'hFF;
        awvalid6 = 1'b1; wvalid6 = 1'b1; bready6 = 1'b1;
        @(negedge clk);
        awvalid6 = 1'b0; wvalid6 = 1'b0;
        check("w64_bvalid", bvalid6, 1);
        check("w64_bresp", bresp6, RESP_OKAY);
        @(negedge clk);
        araddr6 = 8'h18; arvalid6 = 1'b1; rready6 = 1'b1;
        @(negedge clk);
        arvalid6 = 1'b0;
        check("r64_rvalid", rvalid6, 1);
        check("r64_rdata", rdata6, 64'h0123456789ABCDEF);
        check("r64_rresp", rresp6, RESP_OKAY);
        check("r64_reg_out3", reg_out6[3*64 +: 64], 64'h0123456789ABCDEF);
        @(negedge clk);
        arvalid6 = 1'b1; rready6 = 1'b0;
        @(negedge clk);
        arvalid6 = 1'b0;
        check("r64_pending", rvalid6, 1);
        #2 rst6_n = 1'b0;
        #1;
        check("rst64_rvalid", rvalid6, 0);
        check("rst64_reg3", reg_out6[3*64 +: 64], 64'h0);
        check("rst64_arready", arready6, 0);
        @(negedge clk);
        rst6_n = 1'b1; rready6 = 1'b1;
        @(negedge clk);
        check("rst64_release", {arready6, rvalid6}, 2'b10);
        araddr6 = 8'h18; arvalid6 = 1'b1;
        @(negedge clk);
        arvalid6 = 1'b0;
        check("rst64_read_rvalid", rvalid6, 1);
        check("rst64_read_value", rdata6, 64'h0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
